// File: rtl/mem_run_pkg.sv
// Shared types and defaults for the run-control sequencer and its memory port mux.
package mem_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_HOST = 2'd1,
    OWN_CORE = 2'd2
  } owner_t;

  localparam int DONE_PC_DEF = 128;
  localparam int TIMEOUT_DEF = 4000;

  // Memory owner is a pure function of the registered state, so req never reaches mem_*.
  function automatic owner_t owner_of(input state_t s);
    case (s)
      IDLE, HALT: owner_of = OWN_HOST;
      RUN:        owner_of = OWN_CORE;
      default:    owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_run_ctrl_mem_port_mux.sv
// Combinational owner select for the dat_mem write/address/data port and host handshake.
module mem_port_mux
  import mem_run_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  owner_t          owner,
  input  logic            host_valid,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_din,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_din,
  output logic            host_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din
);

  // Route the selected requester onto the memory port; no owner means a quiet port.
  always_comb begin
    host_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (owner)
      OWN_HOST: begin
        host_ready = host_valid;
        mem_we     = host_valid & host_we;
        mem_addr   = host_addr;
        mem_din    = host_din;
      end
      OWN_CORE: begin
        mem_we   = core_we;
        mem_addr = core_addr;
        mem_din  = core_din;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_run_ctrl.sv
// Run-control sequencer: arms the core, runs it on dat_mem, halts on DONE_PC or watchdog.
module mem_run_ctrl
  import mem_run_pkg::*;
#(
  parameter int D       = 12,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int DONE_PC = DONE_PC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            host_valid,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_din,
  output logic            host_ready,
  output logic            host_rvalid,
  output logic [DW-1:0]   host_dout,
  input  logic            core_we,
  input  logic [AW-1:0]   core_addr,
  input  logic [DW-1:0]   core_din,
  output logic [DW-1:0]   core_dout,
  input  logic [D-1:0]    prog_ctr,
  output logic            core_rst,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout,
  output logic            done,
  output logic            timeout,
  output logic [15:0]     cycle_cnt
);

  state_t      state, state_nxt;
  owner_t      owner;
  logic        done_nxt, timeout_nxt;
  logic [15:0] cnt_nxt;
  logic        pc_hit, rd_acc;

  // Run counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign owner     = owner_of(state);
  assign core_rst  = (state != RUN);
  assign core_dout = mem_dout;
  assign pc_hit    = (prog_ctr == D'(DONE_PC));
  assign rd_acc    = (owner == OWN_HOST) && host_valid && !host_we;

  mem_port_mux #(.AW(AW), .DW(DW)) u_mux (
    .owner      (owner),
    .host_valid (host_valid),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_din   (host_din),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_din   (core_din),
    .host_ready (host_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din)
  );

  // Next state plus status/counter updates; PC match outranks watchdog outranks abort.
  always_comb begin
    state_nxt   = state;
    done_nxt    = done;
    timeout_nxt = timeout;
    cnt_nxt     = cycle_cnt;
    case (state)
      IDLE: begin
        if (req && !host_valid) state_nxt = ARM;
      end
      ARM: begin
        state_nxt   = RUN;
        cnt_nxt     = '0;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
      end
      RUN: begin
        cnt_nxt = sat_inc(cycle_cnt);
        if (pc_hit) begin
          state_nxt = HALT;
          done_nxt  = 1'b1;
        end else if (cycle_cnt == 16'(TIMEOUT)) begin
          state_nxt   = HALT;
          timeout_nxt = 1'b1;
        end else if (!req) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      HALT: begin
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, status flags and run counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      cycle_cnt <= cnt_nxt;
    end
  end

  // Host readback register: capture on an accepted read, valid for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      host_dout   <= '0;
    end else begin
      host_rvalid <= rd_acc;
      if (rd_acc) host_dout <= mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_run_ctrl.sv
// Directed bench for mem_run_ctrl with a dat_mem model and a host read-data scoreboard.
module tb_mem_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        host_valid, host_we;
  logic [7:0]  host_addr, host_din;
  logic        host_ready, host_rvalid;
  logic [7:0]  host_dout;
  logic        core_we;
  logic [7:0]  core_addr, core_din, core_dout;
  logic [11:0] prog_ctr;
  logic        core_rst;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_din, mem_dout;
  logic        done, timeout;
  logic [15:0] cycle_cnt;

  logic [7:0]  mem [256];
  logic [7:0]  exp_q [$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  mem_run_ctrl #(.TIMEOUT(60)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_dout   (host_dout),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_din    (core_din),
    .core_dout   (core_dout),
    .prog_ctr    (prog_ctr),
    .core_rst    (core_rst),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .done        (done),
    .timeout     (timeout),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  // dat_mem model: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance through RUN until cycle_cnt hits target, bounded.
  task automatic run_to(input string tag, input logic [15:0] target);
    int n = 0;
    while (cycle_cnt != target && n < 200) begin
      tick();
      n++;
    end
    chk(tag, cycle_cnt, target);
  endtask

  // Scoreboard: every read-data pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (reset === 1'b1 && host_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        chk("rdata", host_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; req = 1'b0; host_valid = 1'b0; host_we = 1'b0;
    host_addr = '0; host_din = '0; core_we = 1'b0; core_addr = '0;
    core_din = '0; prog_ctr = '0;
    tick(); tick();
    chk("rst_core_rst", core_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_dout", host_dout, 0);
    reset = 1'b1;
    tick();

    // Host write then read in IDLE.
    host_valid = 1; host_we = 1; host_addr = 8'h10; host_din = 8'h5A;
    #1;
    chk("idle_wr_ready", host_ready, 1);
    chk("idle_wr_we", mem_we, 1);
    chk("idle_wr_addr", mem_addr, 8'h10);
    tick();
    host_we = 0;
    #1;
    chk("idle_rd_ready", host_ready, 1);
    chk("idle_rd_we", mem_we, 0);
    exp_q.push_back(8'h5A);
    tick();
    host_valid = 0;
    chk("rd_rvalid", host_rvalid, 1);
    chk("rd_dout", host_dout, 8'h5A);
    tick();
    chk("rd_rvalid_1cyc", host_rvalid, 0);

    // req while host busy: ARM waits for host_valid to drop.
    req = 1; host_valid = 1; host_we = 0; host_addr = 8'h10;
    exp_q.push_back(8'h5A);
    tick();
    #1;
    chk("req_busy_ready", host_ready, 1);
    chk("req_busy_addr", mem_addr, 8'h10);
    chk("req_busy_core_rst", core_rst, 1);
    exp_q.push_back(8'h5A);
    tick();
    host_valid = 0;
    tick();
    core_we = 1; core_addr = 8'h20; core_din = 8'h33;
    #1;
    chk("arm_core_rst", core_rst, 1);
    chk("arm_mem_we", mem_we, 0);
    chk("arm_mem_addr", mem_addr, 0);
    tick();
    chk("run_core_rst", core_rst, 0);
    chk("run_cnt0", cycle_cnt, 0);
    chk("run_mem_we", mem_we, 1);
    chk("run_mem_addr", mem_addr, 8'h20);
    chk("run_mem_din", mem_din, 8'h33);
    tick();
    core_we = 0;
    #1;
    chk("run_core_dout", core_dout, 8'h33);
    chk("run_cnt1", cycle_cnt, 1);

    // PC reaches DONE_PC at cycle 50.
    run_to("run_to_50", 16'd50);
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_cnt", cycle_cnt, 51);
    chk("halt_core_rst", core_rst, 1);
    tick();
    chk("halt_cnt_hold", cycle_cnt, 51);
    host_valid = 1; host_we = 0; host_addr = 8'h20;
    #1;
    chk("halt_rd_ready", host_ready, 1);
    exp_q.push_back(8'h33);
    tick();
    host_valid = 0;
    req = 0;
    tick();
    chk("halt_idle_done", done, 1);
    chk("halt_idle_core_rst", core_rst, 1);

    // Abort at cycle 5 with a stalled host read.
    req = 1;
    tick();
    chk("arm_done_kept", done, 1);
    tick();
    chk("rerun_done_clr", done, 0);
    host_valid = 1; host_we = 0; host_addr = 8'h10; core_addr = 8'h30;
    #1;
    chk("run_stall_ready", host_ready, 0);
    chk("run_stall_addr", mem_addr, 8'h30);
    run_to("run_to_5", 16'd5);
    chk("run_stall_ready2", host_ready, 0);
    req = 0;
    tick();
    chk("abort_core_rst", core_rst, 1);
    chk("abort_done", done, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_ready", host_ready, 1);
    exp_q.push_back(8'h5A);
    tick();
    host_valid = 0;
    tick();

    // Watchdog at cycle_cnt == 60.
    req = 1;
    tick(); tick();
    run_to("run_to_60", 16'd60);
    chk("wd_still_run", core_rst, 0);
    tick();
    chk("wd_timeout", timeout, 1);
    chk("wd_done", done, 0);
    chk("wd_cnt", cycle_cnt, 61);
    chk("wd_core_rst", core_rst, 1);
    tick();
    chk("wd_cnt_hold", cycle_cnt, 61);
    req = 0;
    tick();
    chk("wd_idle_timeout", timeout, 1);

    // PC match on the watchdog cycle wins.
    req = 1;
    tick();
    chk("arm_timeout_kept", timeout, 1);
    tick();
    chk("rerun_timeout_clr", timeout, 0);
    run_to("run_to_60b", 16'd60);
    prog_ctr = 12'd128;
    tick();
    prog_ctr = 12'd0;
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_cnt", cycle_cnt, 61);
    req = 0;
    tick();

    // Asynchronous reset in the middle of RUN.
    req = 1;
    tick(); tick();
    run_to("run_to_37", 16'd37);
    core_we = 1; core_addr = 8'h40; core_din = 8'h11;
    host_valid = 1; host_we = 1; host_addr = 8'h50; host_din = 8'h77;
    #1;
    chk("mid_run_addr", mem_addr, 8'h40);
    reset = 0;
    #1;
    chk("arst_core_rst", core_rst, 1);
    chk("arst_mem_we", mem_we, 1);
    chk("arst_mem_addr", mem_addr, 8'h50);
    chk("arst_mem_din", mem_din, 8'h77);
    chk("arst_cnt", cycle_cnt, 0);
    tick();
    host_valid = 0; core_we = 0; req = 0;
    reset = 1;
    tick();
    chk("rel_cnt", cycle_cnt, 0);
    chk("rel_done", done, 0);
    chk("rel_core_rst", core_rst, 1);
    host_valid = 1; host_we = 0; host_addr = 8'h50;
    #1;
    chk("rel_ready", host_ready, 1);
    exp_q.push_back(8'h77);
    tick();
    host_valid = 0;
    tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
